// File: rtl/hero_collision_chk_pkg.sv
// Shared definitions for the hero collision checker: field geometry,
// direction encoding, wall entry layout and the overlap test.
package hero_pkg;

  localparam int COORD_W     = 12;
  localparam int CALC_W      = 14;
  localparam int WALL_W      = 4 * COORD_W;

  localparam int SQUARE_SIDE = 60;
  localparam int STEP        = 1;
  localparam int X_MIN       = 62;
  localparam int X_MAX       = 962;
  localparam int Y_MIN       = 108;
  localparam int Y_MAX       = 708;
  localparam int N_WALLS     = 16;
  localparam int IDX_W       = 4;

  // Signed working-width copies so every range comparison stays signed;
  // mixing in an unsigned constant would silently turn -1 into a huge value.
  localparam logic signed [CALC_W-1:0] SIDE_S  = CALC_W'(SQUARE_SIDE);
  localparam logic signed [CALC_W-1:0] STEP_S  = CALC_W'(STEP);
  localparam logic signed [CALC_W-1:0] X_MIN_S = CALC_W'(X_MIN);
  localparam logic signed [CALC_W-1:0] X_MAX_S = CALC_W'(X_MAX);
  localparam logic signed [CALC_W-1:0] Y_MIN_S = CALC_W'(Y_MIN);
  localparam logic signed [CALC_W-1:0] Y_MAX_S = CALC_W'(Y_MAX);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  // Wall rectangle, half-open [wx0,wx1) x [wy0,wy1); wx0 sits in the MSBs.
  typedef struct packed {
    logic [COORD_W-1:0] wx0;
    logic [COORD_W-1:0] wy0;
    logic [COORD_W-1:0] wx1;
    logic [COORD_W-1:0] wy1;
  } wall_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_DONE
  } state_e;

  function automatic wall_t make_wall(input int x0, input int y0,
                                      input int x1, input int y1);
    wall_t w;
    w.wx0 = COORD_W'(x0);
    w.wy0 = COORD_W'(y0);
    w.wx1 = COORD_W'(x1);
    w.wy1 = COORD_W'(y1);
    return w;
  endfunction

  // Widen a 12-bit coordinate to the signed working width (always >= 0).
  function automatic logic signed [CALC_W-1:0] widen(input logic [COORD_W-1:0] v);
    return $signed({{(CALC_W-COORD_W){1'b0}}, v});
  endfunction

  // True when the hero square at (nx,ny) overlaps the wall; degenerate
  // walls are rejected explicitly because the overlap test alone would
  // still fire for a zero-width wall lying inside the square's span.
  function automatic logic box_hits(input logic signed [CALC_W-1:0] nx,
                                    input logic signed [CALC_W-1:0] ny,
                                    input wall_t w);
    logic empty;
    logic overlap;
    empty   = (w.wx0 >= w.wx1) || (w.wy0 >= w.wy1);
    overlap = (nx < widen(w.wx1)) && ((nx + SIDE_S) > widen(w.wx0)) &&
              (ny < widen(w.wy1)) && ((ny + SIDE_S) > widen(w.wy0));
    return overlap && !empty;
  endfunction

endpackage

// File: rtl/hero_collision_chk_wall_rom.sv
// Wall table: combinational address decode into a registered output,
// so the entry for an address shows up one clock later.
module wall_rom
  import hero_pkg::*;
(
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  output logic [WALL_W-1:0] wall
);

  wall_t wall_d;
  wall_t wall_q;

  // Table contents; unlisted entries are empty rectangles that never hit.
  always_comb begin
    wall_d = make_wall(0, 0, 0, 0);
    case (addr)
      IDX_W'(0): wall_d = make_wall(300, 200, 360, 260);
      IDX_W'(3): wall_d = make_wall(600, 400, 660, 460);
      default:   wall_d = make_wall(0, 0, 0, 0);
    endcase
  end

  // Output register; no reset needed since the checker only reads it a
  // cycle after presenting an address.
  always_ff @(posedge clk) begin
    wall_q <= wall_d;
  end

  assign wall = wall_q;

endmodule

// File: rtl/hero_collision_chk.sv
// Decides whether a one-pixel hero step is blocked by the field edge or
// by any wall, scanning the wall table one entry per two cycles.
module hero_collision_chk
  import hero_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [1:0]         dir,
  input  logic [COORD_W-1:0] x_pos,
  input  logic [COORD_W-1:0] y_pos,
  output logic               busy,
  output logic               done,
  output logic               collision
);

  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic signed [CALC_W-1:0] nx_q, nx_d;
  logic signed [CALC_W-1:0] ny_q, ny_d;
  logic collision_q, collision_d;

  logic signed [CALC_W-1:0] req_nx;
  logic signed [CALC_W-1:0] req_ny;
  logic req_out_of_range;
  logic [WALL_W-1:0] wall_raw;
  wall_t cur_wall;
  logic wall_hit;
  logic last_wall;

  wall_rom u_wall_rom (
    .clk  (clk),
    .addr (idx_q),
    .wall (wall_raw)
  );

  assign cur_wall  = wall_t'(wall_raw);
  assign wall_hit  = box_hits(nx_q, ny_q, cur_wall);
  assign last_wall = (idx_q == IDX_W'(N_WALLS - 1));

  // Prospective corner from the live inputs; only used on the accept edge,
  // after which the latched nx/ny carry the request.
  always_comb begin
    req_nx = widen(x_pos);
    req_ny = widen(y_pos);
    case (dir)
      DIR_UP:    req_ny = widen(y_pos) - STEP_S;
      DIR_LEFT:  req_nx = widen(x_pos) - STEP_S;
      DIR_RIGHT: req_nx = widen(x_pos) + STEP_S;
      DIR_DOWN:  req_ny = widen(y_pos) + STEP_S;
      default:   req_ny = widen(y_pos);
    endcase
    req_out_of_range = (req_nx < X_MIN_S) || ((req_nx + SIDE_S) > X_MAX_S) ||
                       (req_ny < Y_MIN_S) || ((req_ny + SIDE_S) > Y_MAX_S);
  end

  // Next-state logic: accept, range-check, then walk the table until a hit
  // or the last entry.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    collision_d = collision_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          nx_d  = req_nx;
          ny_d  = req_ny;
          idx_d = '0;
          if (req_out_of_range) begin
            collision_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (wall_hit) begin
          collision_d = 1'b1;
          state_d     = ST_DONE;
        end else if (last_wall) begin
          collision_d = 1'b0;
          state_d     = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      nx_q        <= '0;
      ny_q        <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      collision_q <= collision_d;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    collision = collision_q;
  end

endmodule

// File: tb/tb_hero_collision_chk.sv
// Directed bench for hero_collision_chk: table of moves with hand-computed
// latency and result, plus reset-idle and reset-mid-scan sequences.
module tb_hero_collision_chk;

  localparam logic [1:0] D_UP    = 2'b00;
  localparam logic [1:0] D_LEFT  = 2'b01;
  localparam logic [1:0] D_RIGHT = 2'b10;
  localparam logic [1:0] D_DOWN  = 2'b11;

  logic        clk;
  logic        rst;
  logic        req;
  logic [1:0]  dir;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        busy;
  logic        done;
  logic        collision;

  int checks;
  int errors;

  typedef struct {
    string      name;
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  d;
    logic        pulse;
    int          exp_lat;
    logic        exp_coll;
  } vec_t;

  vec_t vecs[10];

  hero_collision_chk dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dir       (dir),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .busy      (busy),
    .done      (done),
    .collision (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison with a FAIL line on mismatch.
  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Issue one request and watch up to 40 cycles after the accept edge.
  // Inputs are scrambled after acceptance; optional req pulses while busy.
  task automatic apply_stimulus(input vec_t v, output int lat, output logic coll,
                                output int n_done, output logic busy_c1,
                                output logic coll_c1, output logic busy_after);
    @(negedge clk);
    x_pos = v.x;
    y_pos = v.y;
    dir   = v.d;
    req   = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    lat        = -1;
    coll       = 1'bx;
    n_done     = 0;
    busy_c1    = 1'bx;
    coll_c1    = 1'bx;
    busy_after = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        busy_c1 = busy;
        coll_c1 = collision;
      end
      if (done) begin
        n_done++;
        if (lat < 0) begin
          lat  = c;
          coll = collision;
        end
      end
      if (lat >= 0 && c == lat + 1) busy_after = busy;
      if (c == 1) begin
        x_pos = 12'd0;
        y_pos = 12'd0;
        dir   = D_LEFT;
      end
      if (v.pulse && c >= 2 && c <= 8) begin
        x_pos = 12'd240;
        y_pos = 12'd200;
        dir   = D_RIGHT;
        req   = 1'b1;
      end else begin
        req = 1'b0;
      end
    end
    req = 1'b0;
  endtask

  initial begin
    int   lat;
    logic coll;
    int   n_done;
    logic busy_c1;
    logic coll_c1;
    logic busy_after;
    logic prev_coll;
    int   spurious;

    checks = 0;
    errors = 0;

    vecs[0] = '{"right_edge_touch", 12'd239, 12'd200, D_RIGHT, 1'b0, 33, 1'b0};
    vecs[1] = '{"hit_wall0",        12'd240, 12'd200, D_RIGHT, 1'b0,  3, 1'b1};
    vecs[2] = '{"hit_wall3_pulses", 12'd540, 12'd400, D_RIGHT, 1'b1,  9, 1'b1};
    vecs[3] = '{"oor_left",         12'd62,  12'd300, D_LEFT,  1'b0,  1, 1'b1};
    vecs[4] = '{"oor_down",         12'd500, 12'd648, D_DOWN,  1'b0,  1, 1'b1};
    vecs[5] = '{"left_edge_ok",     12'd63,  12'd300, D_LEFT,  1'b0, 33, 1'b0};
    vecs[6] = '{"oor_up",           12'd500, 12'd108, D_UP,    1'b0,  1, 1'b1};
    vecs[7] = '{"right_max_ok",     12'd901, 12'd300, D_RIGHT, 1'b0, 33, 1'b0};
    vecs[8] = '{"oor_right",        12'd902, 12'd300, D_RIGHT, 1'b0,  1, 1'b1};
    vecs[9] = '{"oor_x0_left",      12'd0,   12'd300, D_LEFT,  1'b0,  1, 1'b1};

    rst   = 1'b1;
    req   = 1'b0;
    dir   = D_UP;
    x_pos = 12'd0;
    y_pos = 12'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_output("idle_busy", int'(busy), 0);
      check_output("idle_done", int'(done), 0);
      check_output("idle_collision", int'(collision), 0);
    end

    prev_coll = 1'b0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i], lat, coll, n_done, busy_c1, coll_c1, busy_after);
      check_output({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      check_output({vecs[i].name, "_collision"}, int'(coll), int'(vecs[i].exp_coll));
      check_output({vecs[i].name, "_done_count"}, n_done, 1);
      check_output({vecs[i].name, "_busy_c1"}, int'(busy_c1), 1);
      check_output({vecs[i].name, "_busy_after"}, int'(busy_after), 0);
      if (vecs[i].exp_lat > 1)
        check_output({vecs[i].name, "_coll_held"}, int'(coll_c1), int'(prev_coll));
      prev_coll = vecs[i].exp_coll;
    end

    // Reset in cycle 10 of a full scan, with collision=1 left over.
    @(negedge clk);
    x_pos = 12'd239;
    y_pos = 12'd200;
    dir   = D_RIGHT;
    req   = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (10) @(negedge clk);
    check_output("prereset_busy", int'(busy), 1);
    check_output("prereset_coll_held", int'(collision), 1);
    rst = 1'b1;
    #1;
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(done), 0);
    check_output("rst_collision", int'(collision), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    check_output("post_rst_no_done", spurious, 0);

    apply_stimulus(vecs[1], lat, coll, n_done, busy_c1, coll_c1, busy_after);
    check_output("after_rst_latency", lat, 3);
    check_output("after_rst_collision", int'(coll), 1);
    check_output("after_rst_done_count", n_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
